// File: rtl/adpll_phase_det_if.sv
// adpll_phase_det_if
//   Bundles the phase-detector sample inputs and error/lock outputs.
//   master : driver of en/tdc_word/fcw (loop controller or bench)
//   slave  : the phase detector itself
//   en        enable; low parks the detector in IDLE
//   tdc_word  DCO phase word, unsigned, wraps mod 2^TDC_W
//   fcw       frequency command word, unsigned fixed point
//   phase_err signed accumulated phase error
//   err_valid phase_err updated this cycle
//   locked    lock indicator (with hysteresis)
//   rej_cnt   rejected-sample count, saturating
`timescale 1ns/1ps
interface adpll_phase_det_if #(
  parameter int TDC_W = 12,
  parameter int FCW_W = 16,
  parameter int ERR_W = 16
);
  logic                    en;
  logic [TDC_W-1:0]        tdc_word;
  logic [FCW_W-1:0]        fcw;
  logic signed [ERR_W-1:0] phase_err;
  logic                    err_valid;
  logic                    locked;
  logic [7:0]              rej_cnt;

  modport master (output en, tdc_word, fcw,
                  input  phase_err, err_valid, locked, rej_cnt);
  modport slave  (input  en, tdc_word, fcw,
                  output phase_err, err_valid, locked, rej_cnt);
endinterface

// File: rtl/adpll_phase_det.sv
// adpll_phase_det
//   ADPLL digital phase detector. Each reference clock it differentiates the
//   TDC phase word, subtracts the measured DCO increment from the FCW and
//   accumulates the difference into a signed phase error. Samples whose
//   integer increment strays more than DELTA_TOL cycles from the FCW are
//   rejected and replaced by the predicted phase. Lock is reported with
//   hysteresis (LOCK_THR to enter after LOCK_CNT samples, UNLOCK_THR to leave).
// Ports
//   clk   reference clock, posedge
//   rst_n asynchronous active-low reset
//   bus   adpll_phase_det_if slave: en/tdc_word/fcw in,
//         phase_err/err_valid/locked/rej_cnt out
`timescale 1ns/1ps
module adpll_phase_det #(
  parameter int TDC_W      = 12,
  parameter int TDC_FRAC_W = 5,
  parameter int FCW_W      = 16,
  parameter int FCW_FRAC_W = 8,
  parameter int ACC_W      = 24,
  parameter int ERR_W      = 16,
  parameter int LOCK_THR   = 16,
  parameter int UNLOCK_THR = 64,
  parameter int LOCK_CNT   = 16,
  parameter int DELTA_TOL  = 4
) (
  input logic               clk,
  input logic               rst_n,
  adpll_phase_det_if.slave  bus
);
  // Alignment shift from TDC fraction to FCW fraction.
  localparam int SH    = FCW_FRAC_W - TDC_FRAC_W;
  localparam int DI_W  = TDC_W - TDC_FRAC_W;
  localparam int FI_W  = FCW_W - FCW_FRAC_W;
  localparam int DW    = (DI_W > FI_W ? DI_W : FI_W) + 2;
  localparam int MX0   = ACC_W > FCW_W ? ACC_W : FCW_W;
  localparam int SUM_W = (MX0 > TDC_W + SH ? MX0 : TDC_W + SH) + 2;
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  localparam logic signed [SUM_W-1:0] ACC_HI = SUM_W'((64'sd1 <<< (ACC_W-1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] ACC_LO = -ACC_HI - SUM_W'(1);
  localparam logic signed [ACC_W-1:0] ERR_HI = ACC_W'((64'sd1 <<< (ERR_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] ERR_LO = -ERR_HI - ACC_W'(1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  state_t                  state;
  logic [TDC_W-1:0]        prev;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        lcnt;
  logic signed [ERR_W-1:0] phase_err_q;
  logic                    err_valid_q, locked_q;
  logic [7:0]              rej_cnt_q;

  // Combinational per-sample datapath
  logic [TDC_W-1:0]        delta, prev_pred;
  logic [DI_W-1:0]         delta_int;
  logic [FI_W-1:0]         fcw_int;
  logic signed [DW-1:0]    dev;
  logic [DW-1:0]           dev_abs;
  logic                    reject;
  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_sat, acc_new;
  logic signed [ERR_W-1:0] err_new;
  logic [ERR_W-1:0]        err_abs;
  logic                    in_lock, out_lock;

  always_comb begin
    // Modular subtraction unwraps the TDC counter wrap-around.
    delta     = bus.tdc_word - prev;
    delta_int = delta[TDC_W-1:TDC_FRAC_W];
    fcw_int   = bus.fcw[FCW_W-1:FCW_FRAC_W];
    dev       = $signed(DW'(delta_int)) - $signed(DW'(fcw_int));
    dev_abs   = dev[DW-1] ? DW'(-dev) : DW'(dev);
    reject    = dev_abs > DW'(DELTA_TOL);
    prev_pred = prev + TDC_W'(bus.fcw >> SH);

    sum = SUM_W'(acc) + $signed(SUM_W'(bus.fcw)) - $signed(SUM_W'(delta) << SH);
    if (sum > ACC_HI)      acc_sat = ACC_HI[ACC_W-1:0];
    else if (sum < ACC_LO) acc_sat = ACC_LO[ACC_W-1:0];
    else                   acc_sat = sum[ACC_W-1:0];
    acc_new = reject ? acc : acc_sat;

    if (acc_new > ERR_HI)      err_new = ERR_HI[ERR_W-1:0];
    else if (acc_new < ERR_LO) err_new = ERR_LO[ERR_W-1:0];
    else                       err_new = acc_new[ERR_W-1:0];

    // Unsigned magnitude: the most-negative code maps to 2^(ERR_W-1),
    // which is larger than any threshold.
    err_abs  = err_new[ERR_W-1] ? ERR_W'(-err_new) : ERR_W'(err_new);
    in_lock  = err_abs <= ERR_W'(LOCK_THR);
    out_lock = err_abs >  ERR_W'(UNLOCK_THR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prev        <= '0;
      acc         <= '0;
      lcnt        <= '0;
      phase_err_q <= '0;
      err_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      rej_cnt_q   <= '0;
    end else if (!bus.en) begin
      // phase_err deliberately held for the loop filter.
      state       <= IDLE;
      err_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          prev        <= bus.tdc_word;
          acc         <= '0;
          lcnt        <= '0;
          rej_cnt_q   <= '0;
          err_valid_q <= 1'b0;
          state       <= TRACK;
        end
        default: begin
          err_valid_q <= 1'b1;
          phase_err_q <= err_new;
          acc         <= acc_new;
          if (reject) begin
            prev <= prev_pred;
            if (rej_cnt_q != 8'hFF) rej_cnt_q <= rej_cnt_q + 8'd1;
          end else begin
            prev <= bus.tdc_word;
          end
          if (state == LOCKED) begin
            if (out_lock) begin
              state    <= TRACK;
              locked_q <= 1'b0;
              lcnt     <= '0;
            end
          end else if (in_lock) begin
            if (lcnt == CNT_W'(LOCK_CNT - 1)) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
              lcnt     <= '0;
            end else begin
              lcnt <= lcnt + CNT_W'(1);
            end
          end else begin
            lcnt <= '0;
          end
        end
      endcase
    end
  end

  assign bus.phase_err = phase_err_q;
  assign bus.err_valid = err_valid_q;
  assign bus.locked    = locked_q;
  assign bus.rej_cnt   = rej_cnt_q;
endmodule

// File: tb/tb_adpll_phase_det.sv
`timescale 1ns/1ps
module tb_adpll_phase_det;
  logic clk = 1'b0;
  logic rst_n;
  always #15 clk = ~clk;

  adpll_phase_det_if bif ();
  adpll_phase_det dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  int compared = 0, mismatched = 0;

  // Reference model state (integer arithmetic from the behavioural rules)
  bit     m_act, m_valid, m_lock;
  int     m_prev, m_cnt, m_rej, m_err;
  longint m_acc;
  int     ph;

  typedef struct {
    logic        en;
    logic [11:0] tdc;
    logic [15:0] fcw;
    logic        valid;
    int          err;
    logic        lock;
    int          rej;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_valid = 0; m_lock = 0;
    m_prev = 0; m_cnt = 0; m_rej = 0; m_err = 0; m_acc = 0;
  endtask

  task automatic model(input logic e, input logic [11:0] t, input logic [15:0] f);
    int d, di, fi, dv, a;
    if (!e) begin
      m_act = 0; m_valid = 0; m_lock = 0;
      return;
    end
    if (!m_act) begin
      m_act = 1; m_prev = int'(t); m_acc = 0; m_cnt = 0; m_rej = 0; m_valid = 0;
      return;
    end
    d  = (int'(t) - m_prev + 4096) % 4096;
    di = d / 32;
    fi = int'(f) / 256;
    dv = di - fi;
    if (dv < 0) dv = -dv;
    if (dv > 4) begin
      m_prev = (m_prev + int'(f) / 8) % 4096;
      if (m_rej < 255) m_rej++;
    end else begin
      m_acc = m_acc + longint'(f) - longint'(d) * 8;
      if (m_acc > 8388607)  m_acc = 8388607;
      if (m_acc < -8388608) m_acc = -8388608;
      m_prev = int'(t);
    end
    m_err = (m_acc > 32767) ? 32767 : (m_acc < -32768) ? -32768 : int'(m_acc);
    m_valid = 1;
    a = (m_err < 0) ? -m_err : m_err;
    if (m_lock) begin
      if (a > 64) begin m_lock = 0; m_cnt = 0; end
    end else if (a <= 16) begin
      m_cnt++;
      if (m_cnt == 16) begin m_lock = 1; m_cnt = 0; end
    end else begin
      m_cnt = 0;
    end
  endtask

  // Apply one clock of inputs, advance the model, compare all outputs.
  task automatic step(input logic e, input logic [11:0] t, input logic [15:0] f);
    bif.en = e; bif.tdc_word = t; bif.fcw = f;
    @(posedge clk); #1;
    model(e, t, f);
    chk("err_valid", bif.err_valid, m_valid);
    chk("phase_err", $signed(bif.phase_err), m_err);
    chk("locked", bif.locked, m_lock);
    chk("rej_cnt", bif.rej_cnt, m_rej);
  endtask

  // Ramp by inc and step.
  task automatic ramp(input int inc);
    ph = (ph + inc) % 4096;
    step(1'b1, 12'(ph), 16'h4E20);
  endtask

  initial begin
    bit mono_ok;
    int last;
    // en, tdc, fcw, valid, err, locked, rej
    tbl[0] = '{1'b1, 12'h03C, 16'h4E20, 1'b0,   0, 1'b0, 0}; // capture only
    tbl[1] = '{1'b1, 12'hA00, 16'h4E20, 1'b1,   0, 1'b0, 0};
    tbl[2] = '{1'b1, 12'h3C4, 16'h4E20, 1'b1,   0, 1'b0, 0}; // wrap
    tbl[3] = '{1'b1, 12'hD89, 16'h4E20, 1'b1,  -8, 1'b0, 0}; // +9C5
    tbl[4] = '{1'b1, 12'hD89, 16'h4E20, 1'b1,  -8, 1'b0, 1}; // outlier
    tbl[5] = '{1'b1, 12'h111, 16'h4E20, 1'b1,  -8, 1'b0, 1}; // vs predicted
    tbl[6] = '{1'b1, 12'hADD, 16'h4E20, 1'b1, -72, 1'b0, 1}; // +9CC
    tbl[7] = '{1'b0, 12'h555, 16'h4E20, 1'b0, -72, 1'b0, 1}; // disable
    tbl[8] = '{1'b1, 12'h123, 16'h4E20, 1'b0, -72, 1'b0, 0}; // re-capture
    tbl[9] = '{1'b1, 12'hAE7, 16'h4E20, 1'b1,   0, 1'b0, 0};

    rst_n = 1'b0;
    bif.en = 1'b0; bif.tdc_word = '0; bif.fcw = '0;
    model_reset();
    #50;
    chk("rst err_valid", bif.err_valid, 0);
    chk("rst phase_err", $signed(bif.phase_err), 0);
    chk("rst locked", bif.locked, 0);
    chk("rst rej_cnt", bif.rej_cnt, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      bif.en = tbl[i].en; bif.tdc_word = tbl[i].tdc; bif.fcw = tbl[i].fcw;
      @(posedge clk); #1;
      model(tbl[i].en, tbl[i].tdc, tbl[i].fcw);
      chk($sformatf("tbl%0d err_valid", i), bif.err_valid, tbl[i].valid);
      chk($sformatf("tbl%0d phase_err", i), $signed(bif.phase_err), tbl[i].err);
      chk($sformatf("tbl%0d locked", i), bif.locked, tbl[i].lock);
      chk($sformatf("tbl%0d rej_cnt", i), bif.rej_cnt, tbl[i].rej);
    end
    ph = 'hAE7;

    // Lock on exactly the 16th valid zero-error sample
    step(1'b0, 12'(ph), 16'h4E20);
    step(1'b1, 12'(ph), 16'h4E20);
    for (int i = 0; i < 15; i++) ramp(2500);
    chk("lock after 15", bif.locked, 0);
    ramp(2500);
    chk("lock after 16", bif.locked, 1);

    // Hysteresis: +40 holds lock, +72 drops it, relock needs 16 samples
    ramp(2495);
    chk("hyst err40", $signed(bif.phase_err), 40);
    chk("hyst lock40", bif.locked, 1);
    ramp(2496);
    chk("hyst err72", $signed(bif.phase_err), 72);
    chk("hyst lock72", bif.locked, 0);
    ramp(2509);
    for (int i = 0; i < 14; i++) ramp(2500);
    chk("relock after 15", bif.locked, 0);
    ramp(2500);
    chk("relock after 16", bif.locked, 1);

    // Saturation: -8 per sample, must clamp and never wrap
    mono_ok = 1'b1;
    last = $signed(bif.phase_err);
    for (int i = 0; i < 4200; i++) begin
      ramp(2501);
      if ($signed(bif.phase_err) > last) mono_ok = 1'b0;
      last = $signed(bif.phase_err);
    end
    chk("clamp value", $signed(bif.phase_err), -32768);
    chk("clamp no wrap", mono_ok, 1);

    // en=0 mid-TRACK, async reset, re-enable
    step(1'b0, 12'(ph), 16'h4E20);
    chk("dis valid", bif.err_valid, 0);
    chk("dis held err", $signed(bif.phase_err), -32768);
    @(posedge clk); #5;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst err_valid", bif.err_valid, 0);
    chk("arst phase_err", $signed(bif.phase_err), 0);
    chk("arst locked", bif.locked, 0);
    chk("arst rej_cnt", bif.rej_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 12'(ph), 16'h4E20);
    chk("reen first valid", bif.err_valid, 0);
    ramp(2500);
    chk("reen second valid", bif.err_valid, 1);

    // Randomized ramp with jitter, outliers, disables and fcw changes
    for (int i = 0; i < 1500; i++) begin
      int r, inc;
      logic [15:0] f;
      r = int'($urandom_range(0, 99));
      f = (r == 50) ? 16'(32'h4E20 + $urandom_range(0, 64) - 32) : 16'h4E20;
      if (r < 6) inc = int'($urandom_range(0, 4095));
      else       inc = 2500 + int'($urandom_range(0, 24)) - 12;
      ph = (ph + inc) % 4096;
      step((r >= 3) ? 1'b1 : 1'b0, 12'(ph), f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
